// File: rtl/fetch_pc.sv
// Instruction-fetch PC stage: a PC register feeding a one-deep registered output stage with a valid/ready handshake.
// Define FETCH_MISALIGN_TRAP_EN to halt on a misaligned redirect; otherwise the low bits of a redirect are cleared.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] ImemData,
  output logic [31:0] ImemAddr,
  output logic [31:0] InstrOut,
  output logic [31:0] PcOut,
  output logic [31:0] PcPlus4,
  output logic        Valid,
  input  logic        Ready,
  output logic [31:0] FetchCount,
  output logic        Misaligned
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] instr_reg;
  logic [31:0] instr_next;
  logic [31:0] pc_out_reg;
  logic [31:0] pc_out_next;
  logic [31:0] pc_plus4_reg;
  logic [31:0] pc_plus4_next;
  logic        valid_reg;
  logic        valid_next;
  logic [31:0] count_reg;
  logic [31:0] count_next;

  logic        halted;
  logic        transfer;
  logic        misaligned_redirect;
  logic        load_en;
  logic [31:0] redirect_pc;
  logic [31:0] pc_inc;

  // ---------------------------------------------------------------
  // Redirect handling differs between the trapping and default builds
  // ---------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_reg;
  logic misaligned_next;

  assign misaligned_redirect = Branch && (BranchTarget[1:0] != 2'b00);
  assign redirect_pc         = BranchTarget;
`else
  assign misaligned_redirect = 1'b0;
  assign redirect_pc         = BranchTarget & 32'hFFFF_FFFC;
`endif

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state -- HALT is left only through reset
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (misaligned_redirect) begin
          state_next = HALT;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    halted = 1'b0;
    case (state_reg)
      RUN:     halted = 1'b0;
      HALT:    halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------
  // Handshake and datapath next-state
  // ---------------------------------------------------------------
  assign Valid    = valid_reg && !halted;
  assign transfer = Valid && Ready;
  assign load_en  = !Valid || Ready;
  assign pc_inc   = pc_reg + 32'd4;

  always_comb begin
    pc_next       = pc_reg;
    valid_next    = valid_reg;
    instr_next    = instr_reg;
    pc_out_next   = pc_out_reg;
    pc_plus4_next = pc_plus4_reg;
    count_next    = count_reg + {31'd0, transfer};
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_next = misaligned_reg;
`endif

    if (halted) begin
      // Frozen until reset; the output stage is already empty.
      valid_next = 1'b0;
      count_next = count_reg;
    end else if (Branch) begin
      // The word at the old PC is dropped; a transfer this cycle still counts.
      pc_next    = redirect_pc;
      valid_next = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned_redirect) begin
        misaligned_next = 1'b1;
      end
`endif
    end else if (Stall) begin
      if (transfer) begin
        valid_next = 1'b0;
      end
    end else if (load_en) begin
      instr_next    = ImemData;
      pc_out_next   = pc_reg;
      pc_plus4_next = pc_inc;
      valid_next    = 1'b1;
      pc_next       = pc_inc;
    end
  end

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      valid_reg    <= 1'b0;
      instr_reg    <= 32'd0;
      pc_out_reg   <= 32'd0;
      pc_plus4_reg <= 32'd0;
      count_reg    <= 32'd0;
    end else begin
      pc_reg       <= pc_next;
      valid_reg    <= valid_next;
      instr_reg    <= instr_next;
      pc_out_reg   <= pc_out_next;
      pc_plus4_reg <= pc_plus4_next;
      count_reg    <= count_next;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      misaligned_reg <= 1'b0;
    end else begin
      misaligned_reg <= misaligned_next;
    end
  end

  assign Misaligned = misaligned_reg;
`else
  assign Misaligned = 1'b0;
`endif

  assign ImemAddr   = pc_reg;
  assign InstrOut   = instr_reg;
  assign PcOut      = pc_out_reg;
  assign PcPlus4    = pc_plus4_reg;
  assign FetchCount = count_reg;

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: directed scenarios plus randomized traffic checked against a cycle model of the fetch rules.
module tb_fetch_pc;

  localparam logic [31:0] RESET0 = 32'h0000_0000;
  localparam logic [31:0] RESET1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance stimulus and outputs
  logic        rst, stall, branch, ready;
  logic [31:0] target;
  logic [31:0] mem_xor;
  logic [31:0] imem_data0, imem_addr0, instr0, pc_out0, pc_plus4_0, count0;
  logic        valid0, mis0;

  // Wrap-around instance (RESET_PC near the top of the address space)
  logic        rst1;
  logic [31:0] imem_data1, imem_addr1, instr1, pc_out1, pc_plus4_1, count1;
  logic        valid1, mis1;

  assign imem_data0 = imem_addr0 ^ mem_xor;
  assign imem_data1 = imem_addr1;

  fetch_pc #(.RESET_PC(RESET0)) dut0 (
    .clock(clk), .reset(rst), .Stall(stall), .Branch(branch), .BranchTarget(target),
    .ImemData(imem_data0), .ImemAddr(imem_addr0), .InstrOut(instr0), .PcOut(pc_out0),
    .PcPlus4(pc_plus4_0), .Valid(valid0), .Ready(ready), .FetchCount(count0),
    .Misaligned(mis0)
  );

  fetch_pc #(.RESET_PC(RESET1)) dut1 (
    .clock(clk), .reset(rst1), .Stall(1'b0), .Branch(1'b0), .BranchTarget(32'd0),
    .ImemData(imem_data1), .ImemAddr(imem_addr1), .InstrOut(instr1), .PcOut(pc_out1),
    .PcPlus4(pc_plus4_1), .Valid(valid1), .Ready(1'b1), .FetchCount(count1),
    .Misaligned(mis1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state for dut0
  logic [31:0] m_pc, m_instr, m_pcout, m_pc4, m_count;
  logic        m_valid, m_mis, m_halt;

  task automatic model_edge();
    logic xfer;
    if (rst) begin
      m_pc = RESET0; m_valid = 1'b0; m_instr = '0; m_pcout = '0; m_pc4 = '0;
      m_count = '0; m_mis = 1'b0; m_halt = 1'b0;
    end else if (!m_halt) begin
      xfer = m_valid && ready;
      if (xfer) begin
        m_count = m_count + 1;
        $display("xfer pc=%h instr=%h count=%0d", m_pcout, m_instr, m_count);
      end
      if (branch) begin
        m_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        m_pc = target;
        if (target[1:0] != 2'b00) begin
          m_mis  = 1'b1;
          m_halt = 1'b1;
        end
`else
        m_pc = target & 32'hFFFF_FFFC;
`endif
      end else if (stall) begin
        if (xfer) m_valid = 1'b0;
      end else if (!m_valid || ready) begin
        m_instr = m_pc ^ mem_xor;
        m_pcout = m_pc;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    check("imem_addr", imem_addr0, m_pc);
    check("valid", {31'd0, valid0}, {31'd0, m_valid});
    check("instr_out", instr0, m_instr);
    check("pc_out", pc_out0, m_pcout);
    check("pc_plus4", pc_plus4_0, m_pc4);
    check("fetch_count", count0, m_count);
    check("misaligned", {31'd0, mis0}, {31'd0, m_mis});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; ready = 1'b0; target = '0;
    mem_xor = '0; rst1 = 1'b1;

    // Reset state
    step();
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_addr", imem_addr0, 32'd0);
    check("rst_count", count0, 32'd0);

    // Streaming from reset with Ready=1
    rst = 1'b0; ready = 1'b1;
    step();
    check("first_valid", {31'd0, valid0}, 32'd1);
    check("first_pcout", pc_out0, 32'd0);
    check("first_pc4", pc_plus4_0, 32'd4);
    step();
    check("second_pcout", pc_out0, 32'd4);
    step();
    check("third_pcout", pc_out0, 32'd8);
    check("third_pc4", pc_plus4_0, 32'd12);

    // Backpressure: outputs hold at PcOut=8
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_pcout", pc_out0, 32'd8);
      check("bp_instr", instr0, 32'd8);
      check("bp_addr", imem_addr0, 32'd12);
      check("bp_count", count0, 32'd2);
    end
    ready = 1'b1;
    step();
    check("count_after_3", count0, 32'd3);

    // Branch during stall
    stall = 1'b1; branch = 1'b1; target = 32'h0000_0100;
    step();
    check("br_valid", {31'd0, valid0}, 32'd0);
    check("br_addr", imem_addr0, 32'h100);
    stall = 1'b0; branch = 1'b0;
    step();
    check("br_pcout", pc_out0, 32'h100);

    // Reset mid-stall mid-handshake
    ready = 1'b0; stall = 1'b1; rst = 1'b1;
    step();
    check("midrst_valid", {31'd0, valid0}, 32'd0);
    check("midrst_pcout", pc_out0, 32'd0);
    check("midrst_addr", imem_addr0, RESET0);
    rst = 1'b0; stall = 1'b0; ready = 1'b1;
    step();

    // Misaligned redirect
    branch = 1'b1; target = 32'h0000_0102;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_flag", {31'd0, mis0}, 32'd1);
    check("mis_valid", {31'd0, valid0}, 32'd0);
    check("mis_addr", imem_addr0, 32'h102);
    target = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      branch = (i == 1);
      step();
      check("halt_addr", imem_addr0, 32'h102);
      check("halt_valid", {31'd0, valid0}, 32'd0);
    end
`else
    check("mis_addr", imem_addr0, 32'h100);
    check("mis_flag", {31'd0, mis0}, 32'd0);
    branch = 1'b0;
    step();
    check("mis_pcout", pc_out0, 32'h100);
    check("mis_valid", {31'd0, valid0}, 32'd1);
`endif
    branch = 1'b0;

    // Wrap-around instance
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    step();
    check("wrap_pcout0", pc_out1, 32'hFFFF_FFF8);
    check("wrap_valid", {31'd0, valid1}, 32'd1);
    step();
    check("wrap_pcout1", pc_out1, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4_1, 32'h0000_0000);
    step();
    check("wrap_pcout2", pc_out1, 32'h0000_0000);
    check("wrap_addr", imem_addr1, 32'h0000_0004);

    // Randomized traffic against the model
    rst = 1'b1; mem_xor = $urandom;
    step();
    for (int i = 0; i < 2000; i++) begin
      rst    = ($urandom_range(0, 99) < 3);
      stall  = ($urandom_range(0, 99) < 20);
      branch = ($urandom_range(0, 99) < 10);
      ready  = ($urandom_range(0, 99) < 70);
      target = $urandom;
      if ($urandom_range(0, 3) != 0) target[1:0] = 2'b00;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 SHALL have port Stall  input  1  hold the PC and inhibit new fetches.
REQ-005 SHALL have port Branch  input  1  redirect request.
REQ-006 SHALL have port BranchTarget  input  32  redirect address.
REQ-007 SHALL have port ImemData  input  32  instruction word read combinationally at ImemAddr.
REQ-008 SHALL have port ImemAddr  output  32  current PC, driven combinationally from the PC register.
REQ-009 SHALL have port InstrOut  output  32  registered instruction sent to decode.
REQ-010 SHALL have port PcOut  output  32  registered address of InstrOut.
REQ-011 SHALL have port PcPlus4  output  32  registered PcOut+4, used by decode as the link value.
REQ-012 SHALL have port Valid  output  1  output stage holds an instruction.
REQ-013 SHALL have port Ready  input  1  decode accepts the instruction.
REQ-014 SHALL have port FetchCount  output  32  count of accepted transfers.
REQ-015 SHALL have port Misaligned  output  1  sticky misaligned-redirect flag.

Function
REQ-016 SHALL complete a transfer in every cycle in which Valid=1 and Ready=1.
REQ-017 SHALL perform a load in any cycle without reset, Branch, Stall or HALT in which Valid=0 or Ready=1; on a load, InstrOut<=ImemData, PcOut<=PC, PcPlus4<=PC+4, Valid<=1 and PC<=PC+4.
REQ-018 SHALL compute PC+4 modulo 2^32, so that PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-019 SHALL hold InstrOut, PcOut, PcPlus4 and Valid stable while Valid=1 and Ready=0.
REQ-020 SHALL hold the PC while Stall=1; if a transfer occurs during that cycle, Valid<=0, otherwise the output stage holds.
REQ-021 SHALL apply the following priority on Branch=1 (below reset, above Stall and Ready): PC<=BranchTarget, Valid<=0, and the fetch at the old PC discarded.
REQ-022 SHALL still count a transfer that completes in the same cycle as a Branch.
REQ-023 SHALL increment FetchCount by 1 on each transfer, wrapping from 32'hFFFF_FFFF to 0.
REQ-024 SHALL implement the state machine RUN -> HALT on a misaligned redirect (per REQ-034); HALT is exited only by reset.
REQ-025 SHALL, in HALT, force Valid=0, hold the PC, and ignore Branch, Stall and Ready.
REQ-026 SHALL add zero latency from the PC register to ImemAddr, and one cycle from ImemAddr to Valid/InstrOut.

Reset
REQ-027 SHALL set PC<=RESET_PC on reset.
REQ-028 SHALL set Valid<=0, InstrOut<=0, PcOut<=0, PcPlus4<=0, FetchCount<=0, Misaligned<=0 and state<=RUN on reset.
REQ-029 SHALL give reset priority over Branch, Stall and HALT, including reset asserted mid-stall or mid-handshake.
REQ-030 SHALL perform its first load in the cycle after reset deasserts, provided Stall=0 in that cycle.

Configuration
REQ-031 SHALL make the misaligned-redirect trap controlled by the macro FETCH_MISALIGN_TRAP_EN.
REQ-032 SHALL, without FETCH_MISALIGN_TRAP_EN, load BranchTarget with bits [1:0] forced to 2'b00.
REQ-033 SHALL, without FETCH_MISALIGN_TRAP_EN, tie Misaligned to 0 and never enter HALT.
REQ-034 SHALL, with FETCH_MISALIGN_TRAP_EN, on Branch=1 with BranchTarget[1:0]!=0: PC<=BranchTarget unmodified, Misaligned<=1, Valid<=0, and state<=HALT.

Verification
REQ-035 SHALL cover: reset then Ready=1, with ImemData returning the address -> Valid rises 1 cycle after reset release; PcOut=0,4,8; PcPlus4=4,8,12; FetchCount=3 after 3 transfers.
REQ-036 SHALL cover: Valid=1 at PcOut=8 with Ready=0 for 3 cycles -> all outputs constant, ImemAddr=12, FetchCount unchanged.
REQ-037 SHALL cover: Branch=1 with BranchTarget=32'h0000_0100 while Stall=1 -> next cycle Valid=0 and ImemAddr=32'h100; first PcOut after redirect = 32'h100.
REQ-038 SHALL cover: RESET_PC=32'hFFFF_FFF8 with Ready=1 -> PcOut sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; PcPlus4 of FFFF_FFFC = 0.
REQ-039 SHALL cover: BranchTarget=32'h0000_0102 -> with FETCH_MISALIGN_TRAP_EN: Misaligned=1, Valid=0, ImemAddr=32'h102 held until reset; without it: ImemAddr=32'h100 and fetch continues.
REQ-040 SHALL cover: reset asserted while Valid=1, Ready=0, Stall=1 -> next cycle all outputs at reset values and ImemAddr=RESET_PC.
